// File: rtl/div_seq_pkg.sv
// Shared types and helpers for the iterative signed divider.
package div_seq_pkg;

    localparam int REG_W     = 64;
    localparam int DIV_CNT_W = 7;

    typedef logic [REG_W-1:0]     reg_t;
    typedef logic [DIV_CNT_W-1:0] div_cnt_t;

    typedef enum logic [1:0] {
        BMD_08,
        BMD_16,
        BMD_32,
        BMD_64
    } bmd_t;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_DONE
    } div_state_t;

    // Operand width in bits for a given width selector.
    function automatic div_cnt_t bmd_width(input bmd_t bmd);
        case (bmd)
            BMD_08:  return div_cnt_t'(8);
            BMD_16:  return div_cnt_t'(16);
            BMD_32:  return div_cnt_t'(32);
            default: return div_cnt_t'(64);
        endcase
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit and
// subtract the divisor when it fits.
module div_step #(
    parameter int REG_W = 64
) (
    input  logic [REG_W-1:0] rem,
    input  logic             dvd_bit,
    input  logic [REG_W-1:0] dvs,
    output logic [REG_W-1:0] rem_next,
    output logic             q_bit
);

    // One extra bit: the shifted remainder can momentarily exceed REG_W bits.
    logic [REG_W:0] shifted;
    logic [REG_W:0] diff;

    // Trial subtraction; keep it only when the result is non-negative.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        rem_next = '0;
        q_bit    = 1'b0;
        shifted  = {rem, dvd_bit};
        diff     = shifted - {1'b0, dvs};
        if (shifted >= {1'b0, dvs}) begin
            q_bit    = 1'b1;
            rem_next = diff[REG_W-1:0];
        end else begin
            rem_next = shifted[REG_W-1:0];
        end
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed divider: one quotient bit per cycle, valid/ready on
// both sides, flushable mid-operation.
module div_seq #(
    parameter int REG_W = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    flush,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [REG_W-1:0]        s,
    input  logic [REG_W-1:0]        t,
    input  div_seq_pkg::bmd_t       bmd,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [REG_W-1:0]        d,
    output logic [REG_W-1:0]        r,
    output logic                    div_zero
);

    import div_seq_pkg::*;

    localparam int IDX_W = $clog2(REG_W);

    // Low n bits set; all ones when n covers the whole register.
    function automatic logic [REG_W-1:0] width_mask(input div_cnt_t n);
        logic [REG_W-1:0] one;
        one = {{(REG_W-1){1'b0}}, 1'b1};
        if (int'(n) >= REG_W) return '1;
        return (one << n) - one;
    endfunction

    // Sign-extend x from bit n-1, discarding everything above it.
    function automatic logic [REG_W-1:0] sext(input logic [REG_W-1:0] x, input div_cnt_t n);
        logic [REG_W-1:0] m;
        m = width_mask(n);
        return x[IDX_W'(n - div_cnt_t'(1))] ? (x | ~m) : (x & m);
    endfunction

    div_state_t       state;
    div_cnt_t         cnt;
    div_cnt_t         n_w;
    logic [REG_W-1:0] dvd;
    logic [REG_W-1:0] dvs;
    logic [REG_W-1:0] rem;
    logic [REG_W-1:0] quo;
    logic             sign_q;
    logic             sign_r;

    div_cnt_t         n_req;
    logic [REG_W-1:0] s_ext;
    logic [REG_W-1:0] t_ext;
    logic [REG_W-1:0] abs_s;
    logic [REG_W-1:0] abs_t;
    logic             t_zero;

    logic             dvd_bit;
    logic [REG_W-1:0] rem_next;
    logic             q_bit;
    logic [REG_W-1:0] quo_fin;
    logic [REG_W-1:0] d_fin;
    logic [REG_W-1:0] r_fin;

    assign req_ready = (state == DIV_IDLE);

    // Request-side operand conditioning: narrow, sign-extend, take magnitudes.
    always_comb begin
        n_req  = bmd_width(bmd);
        s_ext  = sext(s, n_req);
        t_ext  = sext(t, n_req);
        abs_s  = s_ext[REG_W-1] ? -s_ext : s_ext;
        abs_t  = t_ext[REG_W-1] ? -t_ext : t_ext;
        t_zero = (t_ext == '0);
    end

    // Dividend bits are consumed MSB first, indexed by the down-counter.
    always_comb begin
        dvd_bit = dvd[IDX_W'(cnt - div_cnt_t'(1))];
    end

    div_step #(.REG_W(REG_W)) u_step (
        .rem      (rem),
        .dvd_bit  (dvd_bit),
        .dvs      (dvs),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    // Sign-corrected, width-truncated results for the final step.
    always_comb begin
        quo_fin = {quo[REG_W-2:0], q_bit};
        d_fin   = width_mask(n_w) & (sign_q ? -quo_fin : quo_fin);
        r_fin   = width_mask(n_w) & (sign_r ? -rem_next : rem_next);
    end

    // FSM, iteration state and registered response.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            state      <= DIV_IDLE;
            cnt        <= '0;
            n_w        <= '0;
            dvd        <= '0;
            dvs        <= '0;
            rem        <= '0;
            quo        <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            resp_valid <= 1'b0;
            d          <= '0;
            r          <= '0;
            div_zero   <= 1'b0;
        end else if (flush) begin
            state      <= DIV_IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (req_valid) begin
                        if (t_zero) begin
                            state      <= DIV_DONE;
                            resp_valid <= 1'b1;
                            d          <= '0;
                            r          <= '0;
                            div_zero   <= 1'b1;
                        end else begin
                            state    <= DIV_CALC;
                            cnt      <= n_req;
                            n_w      <= n_req;
                            dvd      <= abs_s;
                            dvs      <= abs_t;
                            rem      <= '0;
                            quo      <= '0;
                            sign_q   <= s_ext[REG_W-1] ^ t_ext[REG_W-1];
                            sign_r   <= s_ext[REG_W-1];
                            div_zero <= 1'b0;
                        end
                    end
                end
                DIV_CALC: begin
                    rem <= rem_next;
                    quo <= quo_fin;
                    cnt <= cnt - div_cnt_t'(1);
                    if (cnt == div_cnt_t'(1)) begin
                        state      <= DIV_DONE;
                        resp_valid <= 1'b1;
                        d          <= d_fin;
                        r          <= r_fin;
                    end
                end
                DIV_DONE: begin
                    if (resp_ready) begin
                        state      <= DIV_IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus random ops
// against an arithmetic reference model.
module tb_div_seq;

    import div_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] s;
    logic [63:0] t;
    bmd_t        bmd;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] d;
    logic [63:0] r;
    logic        div_zero;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_seq #(.REG_W(64)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush      (flush),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .s          (s),
        .t          (t),
        .bmd        (bmd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .d          (d),
        .r          (r),
        .div_zero   (div_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: signed truncating division on sign-extended N-bit operands.
    task automatic model(input bmd_t b, input logic [63:0] sv, input logic [63:0] tv,
                         output logic [63:0] ed, output logic [63:0] er,
                         output logic edz, output int n);
        longint ss, tt, q, rm;
        logic [63:0] m;
        int sh;
        n  = (b == BMD_08) ? 8 : (b == BMD_16) ? 16 : (b == BMD_32) ? 32 : 64;
        sh = 64 - n;
        ss = $signed(sv);
        ss = (ss <<< sh) >>> sh;
        tt = $signed(tv);
        tt = (tt <<< sh) >>> sh;
        m  = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
        edz = 1'b0;
        if (tt == 0) begin
            q = 0; rm = 0; edz = 1'b1;
        end else if (tt == -1) begin
            q = -ss; rm = 0;
        end else begin
            q = ss / tt; rm = ss % tt;
        end
        ed = 64'(q) & m;
        er = 64'(rm) & m;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction; bp = cycles of held-off resp_ready in DONE.
    task automatic do_op(input bmd_t b, input logic [63:0] sv, input logic [63:0] tv, input int bp);
        logic [63:0] ed, er, d0, r0;
        logic        edz;
        int          n, lat;
        model(b, sv, tv, ed, er, edz, n);
        check("req_ready_before", 64'(req_ready), 64'd1);
        req_valid = 1'b1; s = sv; t = tv; bmd = b;
        step();
        req_valid = 1'b0;
        s = {$urandom, $urandom};
        t = {$urandom, $urandom};
        lat = 1;
        while (!resp_valid && lat < 80) begin
            step();
            lat++;
        end
        check("latency", 64'(lat), edz ? 64'd1 : 64'(n + 1));
        check("d", d, ed);
        check("r", r, er);
        check("div_zero", 64'(div_zero), 64'(edz));
        d0 = d; r0 = r;
        for (int i = 0; i < bp; i++) begin
            step();
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_d", d, d0);
            check("bp_r", r, r0);
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("resp_valid_after", 64'(resp_valid), 64'd0);
        check("req_ready_after", 64'(req_ready), 64'd1);
    endtask

    // Abort a 64-bit op in its 10th CALC cycle via flush (use_rst=0) or reset.
    task automatic abort_op(input bit use_rst);
        int seen;
        req_valid = 1'b1; s = 64'd12345678; t = 64'd3; bmd = BMD_64;
        step();
        req_valid = 1'b0;
        repeat (9) step();
        check("abort_busy", 64'(req_ready), 64'd0);
        if (use_rst) rstn = 1'b0; else flush = 1'b1;
        step();
        rstn = 1'b1; flush = 1'b0;
        check(use_rst ? "rst_idle" : "flush_idle", 64'(req_ready), 64'd1);
        if (use_rst) begin
            check("rst_d", d, 64'd0);
            check("rst_r", r, 64'd0);
        end
        seen = 0;
        repeat (70) begin
            if (resp_valid) seen++;
            step();
        end
        check("abort_no_resp", 64'(seen), 64'd0);
        do_op(BMD_64, -64'sd9, 64'd2, 0);
    endtask

    initial begin
        bmd_t rb;
        logic [63:0] rs, rt;
        rstn = 1'b0; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
        s = '0; t = '0; bmd = BMD_64;
        step();
        step();
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_d", d, 64'd0);
        check("rst_r", r, 64'd0);
        check("rst_div_zero", 64'(div_zero), 64'd0);
        rstn = 1'b1;
        step();

        do_op(BMD_64, 64'd100, 64'd7, 0);
        do_op(BMD_08, 64'hFFFF_FFFF_FFFF_FFF9, 64'h1234_0002, 0);
        do_op(BMD_32, 64'h8000_0000, 64'hFFFF_FFFF, 0);
        do_op(BMD_64, 64'h8000_0000_0000_0000, '1, 0);
        do_op(BMD_16, 64'd1234, 64'h1_0000, 0);
        do_op(BMD_32, -64'sd1000, 64'd7, 5);
        do_op(BMD_16, 64'd77, -64'sd5, 0);

        // flush beats a simultaneous request in IDLE
        req_valid = 1'b1; flush = 1'b1; s = 64'd5; t = 64'd1; bmd = BMD_08;
        step();
        req_valid = 1'b0; flush = 1'b0;
        check("flush_wins_ready", 64'(req_ready), 64'd1);
        check("flush_wins_valid", 64'(resp_valid), 64'd0);

        abort_op(1'b0);
        abort_op(1'b1);

        for (int i = 0; i < 60; i++) begin
            rb = bmd_t'($urandom_range(0, 3));
            rs = {$urandom, $urandom};
            rt = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rt = rt & 64'hFFFF_FFFF_FFFF_FF00;
                1: rt = '1;
                2: rs = 64'h8000_0000_0000_0000 >> (64 - 8 * (1 << rb));
                3: rt = 64'($urandom_range(1, 20));
                default: ;
            endcase
            do_op(rb, rs, rt, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
